alu_arbiter: RTL and testbench

Shares one combinational 32-bit ALU between two requesters, such as the integer pipeline and a debug/config port. Uses round-robin arbitration with valid/ready request and response handshakes. Operands are captured on grant, and the result is registered and held until its owner accepts it. Sits between the requesters and the single instance of module ALU.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 29 ++
 rtl/ALU.sv | 26 ++
 rtl/alu_arbiter_rr_arb2.sv | 32 +++
 rtl/alu_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_arbiter.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: the ALU op codes, the FSM
// state encoding and the datapath width.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the shared ALU arbiter.
// Requester i owns the slice [W*i +: W] of each packed per-requester field.
interface alu_arbiter_if #(
  parameter int unsigned TAG_W = 4
);
  import alu_pkg::*;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_ope1;
  logic [2*DATA_W-1:0] req_ope2;
  logic [5:0]          req_aluop;
  logic [2*TAG_W-1:0]  req_tag;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W-1:0]   rsp_resultado;
  logic [TAG_W-1:0]    rsp_tag;

  modport master (
    output req_valid, req_ope1, req_ope2, req_aluop, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_resultado, rsp_tag
  );

  modport slave (
    input  req_valid, req_ope1, req_ope2, req_aluop, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_resultado, rsp_tag
  );

endinterface

// File: rtl/ALU.sv
// Combinational 32-bit ALU shared by the arbiter. SLT is an unsigned compare.
// Undefined op codes give 0.
module ALU
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] ope1,
  input  logic [DATA_W-1:0] ope2,
  input  logic [2:0]        aluop,
  output logic [DATA_W-1:0] Resultado
);

  always_comb begin
    Resultado = '0;
    case (aluop)
      OP_AND:  Resultado = ope1 & ope2;
      OP_OR:   Resultado = ope1 | ope2;
      OP_ADD:  Resultado = ope1 + ope2;
      OP_SUB:  Resultado = ope1 - ope2;
      OP_SLT:  Resultado = (ope1 < ope2) ? DATA_W'(1) : '0;
      OP_NOR:  Resultado = ~(ope1 | ope2);
      OP_XOR:  Resultado = ope1 ^ ope2;
      default: Resultado = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant. When both requesters are valid, the grant goes to
// the requester that did not win last time. The pointer resets to 1.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
    last_d = (|gnt) ? gnt[1] : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: grant in IDLE, compute in EXEC, and
// hold the result in RESP until its owner accepts it. ALU_ARB_STATS_EN adds
// grant_cnt, a set of saturating per-requester grant counters.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_arbiter_if.slave       bus,
`ifdef ALU_ARB_STATS_EN
  output logic [NUM_REQ-1:0][15:0] grant_cnt,
`endif
  output logic               busy
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   ope1_q, ope1_d;
  logic [DATA_W-1:0]   ope2_q, ope2_d;
  logic [2:0]          aluop_q, aluop_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_resultado_q, rsp_resultado_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic                busy_q, busy_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [DATA_W-1:0]   alu_res;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == IDLE),
    .req   (bus.req_valid),
    .gnt   (gnt)
  );

  ALU u_alu (
    .ope1      (ope1_q),
    .ope2      (ope2_q),
    .aluop     (aluop_q),
    .Resultado (alu_res)
  );

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    ope1_d          = ope1_q;
    ope2_d          = ope2_q;
    aluop_d         = aluop_q;
    tag_d           = tag_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_resultado_d = rsp_resultado_q;
    rsp_tag_d       = rsp_tag_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          ope1_d  = gnt[1] ? bus.req_ope1[DATA_W +: DATA_W] : bus.req_ope1[0 +: DATA_W];
          ope2_d  = gnt[1] ? bus.req_ope2[DATA_W +: DATA_W] : bus.req_ope2[0 +: DATA_W];
          aluop_d = gnt[1] ? bus.req_aluop[3 +: 3] : bus.req_aluop[0 +: 3];
          tag_d   = gnt[1] ? bus.req_tag[TAG_W +: TAG_W] : bus.req_tag[0 +: TAG_W];
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_resultado_d = alu_res;
        rsp_tag_d       = tag_q;
        rsp_valid_d     = owner_q ? 2'b10 : 2'b01;
        state_d         = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      ope1_q          <= '0;
      ope2_q          <= '0;
      aluop_q         <= '0;
      tag_q           <= '0;
      rsp_valid_q     <= '0;
      rsp_resultado_q <= '0;
      rsp_tag_q       <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      ope1_q          <= ope1_d;
      ope2_q          <= ope2_d;
      aluop_q         <= aluop_d;
      tag_q           <= tag_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_resultado_q <= rsp_resultado_d;
      rsp_tag_q       <= rsp_tag_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.req_ready     = gnt;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_resultado = rsp_resultado_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign busy              = busy_q;

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && grant_cnt_q[i] != 16'hFFFF) grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) grant_cnt_q <= '0;
    else        grant_cnt_q <= grant_cnt_d;
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single operations plus
// hand-written sequences for arbitration, response hold and mid-operation reset.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
`ifdef ALU_ARB_STATS_EN
  logic [1:0][15:0] grant_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  alu_arbiter_if #(.TAG_W(4)) bus ();

  alu_arbiter #(.NUM_REQ(2), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt (grant_cnt),
`endif
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          req;
    logic [31:0] ope1;
    logic [31:0] ope2;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] tag);
    bus.req_ope1[32*r +: 32] = a;
    bus.req_ope2[32*r +: 32] = b;
    bus.req_aluop[3*r +: 3]  = op;
    bus.req_tag[4*r +: 4]    = tag;
    bus.req_valid[r]         = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single request on requester r, accepted as soon as it is offered.
  task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] tag, input logic [31:0] exp);
    logic [1:0] onehot;
    int cnt;
    onehot = (r == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(r, a, b, op, tag);
    #1;
    cnt = 0;
    while (bus.req_ready == 2'b00 && cnt < 10) begin
      @(negedge clk); #1;
      cnt++;
    end
    check("op_grant", 32'(bus.req_ready), 32'(onehot));
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("op_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("op_exec_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("op_rsp_valid", 32'(bus.rsp_valid), 32'(onehot));
    check("op_result", bus.rsp_resultado, exp);
    check("op_tag", 32'(bus.rsp_tag), 32'(tag));
    bus.rsp_ready[r] = 1'b1;
    @(negedge clk); #1;
    check("op_done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("op_done_busy", 32'(busy), 32'd0);
    bus.rsp_ready = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_g;
    vecs[0] = '{0, 32'd5,          32'd3,          3'b010, 4'hA, 32'd8};
    vecs[1] = '{1, 32'd0,          32'd1,          3'b110, 4'h1, 32'hFFFF_FFFF};
    vecs[2] = '{0, 32'hFFFF_FFFF,  32'd1,          3'b111, 4'h2, 32'd0};
    vecs[3] = '{1, 32'd1,          32'hFFFF_FFFF,  3'b111, 4'h3, 32'd1};
    vecs[4] = '{0, 32'h1234_5678,  32'h9ABC_DEF0,  3'b011, 4'h4, 32'd0};
    vecs[5] = '{1, 32'hF0F0_1234,  32'h0FF0_FF00,  3'b000, 4'h5, 32'h00F0_1200};
    vecs[6] = '{0, 32'h0000_0F00,  32'h0000_00F0,  3'b001, 4'h6, 32'h0000_0FF0};
    vecs[7] = '{1, 32'd0,          32'd0,          3'b100, 4'h7, 32'hFFFF_FFFF};
    vecs[8] = '{0, 32'hAAAA_5555,  32'hFFFF_0000,  3'b101, 4'h8, 32'h5555_5555};
    vecs[9] = '{1, 32'hFFFF_FFFF,  32'd2,          3'b010, 4'hF, 32'd1};

    bus.req_valid = '0;
    bus.req_ope1  = '0;
    bus.req_ope2  = '0;
    bus.req_aluop = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = '0;
    do_reset();
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", bus.rsp_resultado, 32'd0);
    check("reset_tag", 32'(bus.rsp_tag), 32'd0);

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].req, vecs[i].ope1, vecs[i].ope2, vecs[i].op, vecs[i].tag, vecs[i].exp);

    // Both requesters continuously valid: grants alternate starting at 0.
    do_reset();
    @(negedge clk);
    drive(0, 32'd10, 32'd1, 3'b010, 4'h1);
    drive(1, 32'd10, 32'd1, 3'b110, 4'h2);
    bus.rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_grant", 32'(bus.req_ready), 32'(exp_g));
      @(negedge clk); #1;
      check("rr_exec_busy", 32'(busy), 32'd1);
      @(negedge clk); #1;
      check("rr_rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
      check("rr_result", bus.rsp_resultado, (k % 2 == 0) ? 32'd11 : 32'd9);
      check("rr_tag", 32'(bus.rsp_tag), (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk); #1;
    end
    bus.req_valid = '0;
    #1;
    check("rr_drop_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk); #1;
    check("rr_drop_busy", 32'(busy), 32'd0);
    bus.rsp_ready = '0;

    // Response held for 10 cycles while req1 waits; non-owner ready ignored.
    @(negedge clk);
    drive(0, 32'd7, 32'd6, 3'b010, 4'h3);
    #1;
    check("hold_grant0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    drive(1, 32'h0000_FF00, 32'h0000_0FF0, 3'b000, 4'h5);
    #1;
    check("hold_exec_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk); #1;
    check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 2'b10;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      check("hold_rsp_valid_stable", 32'(bus.rsp_valid), 32'd1);
      check("hold_result_stable", bus.rsp_resultado, 32'd13);
      check("hold_tag_stable", 32'(bus.rsp_tag), 32'd3);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk); #1;
    check("hold_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("hold_grant1", 32'(bus.req_ready), 32'd2);
    bus.rsp_ready = '0;
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk); #1;
    check("hold_req1_rsp_valid", 32'(bus.rsp_valid), 32'd2);
    check("hold_req1_result", bus.rsp_resultado, 32'h0000_0F00);
    check("hold_req1_tag", 32'(bus.rsp_tag), 32'd5);
    bus.rsp_ready = 2'b10;
    @(negedge clk); #1;
    check("hold_req1_done", 32'(busy), 32'd0);
    bus.rsp_ready = '0;

    // Reset during EXEC discards the request and restores requester-0 priority.
    @(negedge clk);
    drive(0, 32'd1, 32'd1, 3'b010, 4'h9);
    #1;
    check("rst_grant0", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("rst_exec_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    drive(0, 32'd20, 32'd22, 3'b010, 4'hC);
    drive(1, 32'd3, 32'd3, 3'b101, 4'hD);
    #1;
    check("rst_both_grant", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk); #1;
    check("rst_rsp_valid_new", 32'(bus.rsp_valid), 32'd1);
    check("rst_result_new", bus.rsp_resultado, 32'd42);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = '0;

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) do_op(1, 32'd2, 32'd2, 3'b010, 4'h1, 32'd4);
    check("stats_cnt1", 32'(grant_cnt[1]), 32'd3);
    check("stats_cnt0", 32'(grant_cnt[0]), 32'd0);
    @(negedge clk);
    force dut.grant_cnt_q = {16'hFFFF, 16'h0000};
    @(negedge clk);
    release dut.grant_cnt_q;
    do_op(1, 32'd2, 32'd2, 3'b010, 4'h1, 32'd4);
    check("stats_sat", 32'(grant_cnt[1]), 32'h0000_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
